// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter and three-state sequencer for the shared data-memory/MMIO port.
// Latency: request seen at edge k -> memory strobe in cycle k..k+1 -> one-cycle ack in cycle k+1..k+2.
// Backpressure: a master holds req until its ack; the losing master waits, and its req is served on the next grant.
//
// Ports:
//   clk, reset                       clock; asynchronous active-high reset
//   m0_* / m1_*                      master request/ack handshake (0 = MEM stage, 1 = boot/debug loader)
//   mem_addr/mem_wdata/mem_read/mem_write/mem_rdata   single memory port (mem_rdata is combinational)
//   err                              access fault flag, one cycle alongside the ack
// Build option: define DMEM_ARB_ERR_EN to decode the address at grant and fault illegal accesses;
// without it every access is forwarded and err is tied low.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic              owner;
    logic              last;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic              xfer_ok;

    logic              grant_vld;
    logic              grant_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    // Grant decision. In DONE only the non-owner can be granted: the owner
    // has just been acked and its req still reflects the finished transaction.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    grant_vld = 1'b1;
                    grant_id  = !last;
                end else if (m0_req) begin
                    grant_vld = 1'b1;
                    grant_id  = 1'b0;
                end else if (m1_req) begin
                    grant_vld = 1'b1;
                    grant_id  = 1'b1;
                end
            end
            DONE: begin
                if (owner ? m0_req : m1_req) begin
                    grant_vld = 1'b1;
                    grant_id  = !owner;
                end
            end
            default: ;
        endcase
    end

    assign sel_addr  = grant_id ? m1_addr  : m0_addr;
    assign sel_wdata = grant_id ? m1_wdata : m0_wdata;
    assign sel_we    = grant_id ? m1_we    : m0_we;

    // Strobes are decoded from state so an asynchronous reset mid-XFER
    // withdraws a pending write before the memory can commit it.
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_write = (state == XFER) && xfer_ok && lat_we;
    assign mem_read  = (state == XFER) && xfer_ok && !lat_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (grant_vld) begin
                        state     <= XFER;
                        owner     <= grant_id;
                        last      <= grant_id;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        lat_we    <= sel_we;
                    end else begin
                        state <= IDLE;
                    end
                end
                XFER: begin
                    state <= DONE;
                    if (owner) m1_ack <= 1'b1;
                    else       m0_ack <= 1'b1;
                    // Faulted accesses return zero; good writes leave rdata alone.
                    if (!xfer_ok) begin
                        if (owner) m1_rdata <= '0;
                        else       m0_rdata <= '0;
                    end else if (!lat_we) begin
                        if (owner) m1_rdata <= mem_rdata;
                        else       m0_rdata <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_ERR_EN
    logic lat_bad;

    // Legal map: 2 KiB RAM at 0, plus TH/TL/TCON/digit registers; word-aligned only.
    function automatic logic addr_illegal(input logic [ADDR_W-1:0] a);
        logic mapped;
        mapped = (a < ADDR_W'(32'h0000_0800)) ||
                 (a == ADDR_W'(32'h4000_0000)) ||
                 (a == ADDR_W'(32'h4000_0004)) ||
                 (a == ADDR_W'(32'h4000_0008)) ||
                 (a == ADDR_W'(32'h4000_0010));
        return !(mapped && (a[1:0] == 2'b00));
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_bad <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (grant_vld) lat_bad <= addr_illegal(sel_addr);
            err <= (state == XFER) && lat_bad;
        end
    end

    assign xfer_ok = !lat_bad;
`else
    assign xfer_ok = 1'b1;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized two-master run.
// Latency: checks strobes one cycle after the grant edge and acks one cycle later.
// Backpressure: masters hold req until their ack; all waits are cycle-bounded.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    txn_t        q0[$];
    txn_t        q1[$];
    logic [31:0] ref_mem [logic [31:0]];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .err(err)
    );

    // ---------------- memory environment: 2 KiB RAM + MMIO window ----------------
    function automatic logic [31:0] init_val(input int i);
        case (i)
            0:       return 32'h0000_0064;
            1:       return 32'h0000_000A;
            5:       return 32'd12;
            default: return 32'h0000_1000 + 32'(i) * 4;
        endcase
    endfunction

    logic [31:0] ram  [0:511];
    logic [31:0] mmio [0:7];
    logic        mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 512; i++) ram[i] <= init_val(i);
            for (int i = 0; i < 8; i++) mmio[i] <= 32'h0;
            mem_ready <= 1'b1;
        end else if (mem_write) begin
            if (mem_addr < 32'h800) ram[mem_addr[10:2]] <= mem_wdata;
            else if (mem_addr[31:5] == 27'h200_0000) mmio[mem_addr[4:2]] <= mem_wdata;
        end
    end

    always_comb begin
        mem_rdata = 32'hBAD0_BAD0;
        if (mem_addr < 32'h800) mem_rdata = ram[mem_addr[10:2]];
        else if (mem_addr[31:5] == 27'h200_0000) mem_rdata = mmio[mem_addr[4:2]];
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        if (a < 32'h800) return init_val(int'(a >> 2));
        return 32'h0;
    endfunction

    task automatic set_m(input int m, input logic r, input txn_t t);
        if (m == 0) begin
            m0_req = r; m0_we = t.we; m0_addr = t.addr; m0_wdata = t.wdata;
        end else begin
            m1_req = r; m1_we = t.we; m1_addr = t.addr; m1_wdata = t.wdata;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m0_ack, m1_ack, mem_read, mem_write, err} !== 5'b0)
            $display("FAIL reset_flags got %b want 00000", {m0_ack, m1_ack, mem_read, mem_write, err});
        checks++;
        if ({mem_addr, mem_wdata, m0_rdata, m1_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h want all 0", mem_addr, mem_wdata, m0_rdata, m1_rdata);
        end
        if ({m0_ack, m1_ack, mem_read, mem_write, err} !== 5'b0) errors++;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_ack, m1_ack, mem_read, mem_write} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset got %b want 0000", {m0_ack, m1_ack, mem_read, mem_write});
        end
    endtask

    task automatic test_mmio_write_read();
        m0_req = 1; m0_we = 1; m0_addr = 32'h4000_0010; m0_wdata = 32'h0000_000F;
        @(negedge clk);
        checks++;
        if ({mem_write, mem_read, m0_ack} !== 3'b100 || mem_addr !== 32'h4000_0010 || mem_wdata !== 32'hF) begin
            errors++;
            $display("FAIL wr_xfer got w%b r%b ack%b a=%h d=%h want w1 r0 ack0 a=40000010 d=f",
                     mem_write, mem_read, m0_ack, mem_addr, mem_wdata);
        end
        m0_req = 0; m0_we = 0; m0_wdata = 0;
        @(negedge clk);
        checks++;
        if ({m0_ack, m1_ack, mem_write} !== 3'b100) begin
            errors++;
            $display("FAIL wr_ack got %b want 100", {m0_ack, m1_ack, mem_write});
        end
        m0_req = 1;                     // new read presented during DONE: ignored this cycle
        @(negedge clk);
        checks++;
        if ({m0_ack, mem_read} !== 2'b00) begin
            errors++;
            $display("FAIL rd_idle_gap got %b want 00", {m0_ack, mem_read});
        end
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h4000_0010) begin
            errors++;
            $display("FAIL rd_xfer got r%b a=%h want r1 a=40000010", mem_read, mem_addr);
        end
        m0_req = 0;
        @(negedge clk);
        checks++;
        if (m0_ack !== 1'b1 || m0_rdata !== 32'hF || err !== 1'b0) begin
            errors++;
            $display("FAIL rd_data got ack%b d=%h err%b want ack1 d=f err0", m0_ack, m0_rdata, err);
        end
        @(negedge clk);
    endtask

    task automatic test_tie();
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'h0;
        m1_req = 1; m1_we = 0; m1_addr = 32'h4;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL tie_first got r%b a=%h want r1 a=0", mem_read, mem_addr);
        end
        m0_req = 0;
        @(negedge clk);
        checks++;
        if ({m0_ack, m1_ack} !== 2'b10 || m0_rdata !== 32'h64) begin
            errors++;
            $display("FAIL tie_m0_ack got acks=%b d=%h want 10 d=64", {m0_ack, m1_ack}, m0_rdata);
        end
        @(negedge clk);
        checks++;
        if ({m0_ack, m1_ack} !== 2'b00 || mem_read !== 1'b1 || mem_addr !== 32'h4) begin
            errors++;
            $display("FAIL tie_m1_xfer got acks=%b r%b a=%h want 00 r1 a=4", {m0_ack, m1_ack}, mem_read, mem_addr);
        end
        m1_req = 0;
        @(negedge clk);
        checks++;
        if ({m0_ack, m1_ack} !== 2'b01 || m1_rdata !== 32'hA) begin
            errors++;
            $display("FAIL tie_m1_ack got acks=%b d=%h want 01 d=a", {m0_ack, m1_ack}, m1_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_alternate();
        int got;
        int prev;
        logic [1:0] exp;
        got = 0;
        prev = 0;
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'h18;
        m1_req = 1; m1_we = 0; m1_addr = 32'h1C;
        for (int c = 0; c < 60 && got < 6; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                exp = (got % 2 == 0) ? 2'b10 : 2'b01;
                checks++;
                if ({m0_ack, m1_ack} !== exp) begin
                    errors++;
                    $display("FAIL alt_order ack#%0d got %b want %b", got, {m0_ack, m1_ack}, exp);
                end
                if (got > 0) begin
                    checks++;
                    if (c - prev != 2) begin
                        errors++;
                        $display("FAIL alt_spacing ack#%0d got %0d cycles want 2", got, c - prev);
                    end
                end
                prev = c;
                got++;
                if (got == 6) begin
                    m0_req = 0; m1_req = 0;
                end
            end
        end
        m0_req = 0; m1_req = 0;
        checks++;
        if (got != 6) begin
            errors++;
            $display("FAIL alt_timeout got %0d acks want 6", got);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_hold_m1();
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'hC;
        @(negedge clk);
        m1_req = 1; m1_we = 0; m1_addr = 32'h10;
        m0_addr = 32'h7FC;              // changed after the grant edge
        #1;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 32'hC || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL hold_xfer_m0 got r%b a=%h ack1=%b want r1 a=c ack1=0", mem_read, mem_addr, m1_ack);
        end
        m0_req = 0;
        @(negedge clk);
        checks++;
        if ({m0_ack, m1_ack} !== 2'b10 || m0_rdata !== 32'h100C) begin
            errors++;
            $display("FAIL hold_m0_ack got acks=%b d=%h want 10 d=100c", {m0_ack, m1_ack}, m0_rdata);
        end
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL hold_xfer_m1 got r%b a=%h want r1 a=10", mem_read, mem_addr);
        end
        m1_req = 0;
        @(negedge clk);
        checks++;
        if ({m0_ack, m1_ack} !== 2'b01 || m1_rdata !== 32'h1010) begin
            errors++;
            $display("FAIL hold_m1_ack got acks=%b d=%h want 01 d=1010", {m0_ack, m1_ack}, m1_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_xfer();
        m1_req = 1; m1_we = 1; m1_addr = 32'h14; m1_wdata = 32'hDEAD_0005;
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1 || mem_addr !== 32'h14) begin
            errors++;
            $display("FAIL rst_xfer got w%b a=%h want w1 a=14", mem_write, mem_addr);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_write got w%b want w0", mem_write);
        end
        m1_req = 0; m1_we = 0;
        @(negedge clk);
        checks++;
        if ({m1_ack, m0_ack, mem_write} !== 3'b000) begin
            errors++;
            $display("FAIL rst_no_ack got %b want 000", {m1_ack, m0_ack, mem_write});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ram[5] !== 32'd12 || {m1_ack, mem_read, mem_write} !== 3'b000) begin
            errors++;
            $display("FAIL rst_word5 got %h flags=%b want c 000", ram[5], {m1_ack, mem_read, mem_write});
        end
        m0_req = 1; m0_we = 0; m0_addr = 32'h14;
        @(negedge clk);
        m0_req = 0;
        @(negedge clk);
        checks++;
        if (m0_ack !== 1'b1 || m0_rdata !== 32'd12) begin
            errors++;
            $display("FAIL rst_readback got ack%b d=%h want ack1 d=c", m0_ack, m0_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_err();
        logic [31:0] want_d;
        m0_req = 1; m0_we = 0; m0_addr = 32'h4000_0020;
        @(negedge clk);
        checks++;
        if (mem_read !== !ERR_EN || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL err_xfer got r%b w%b want r%b w0", mem_read, mem_write, !ERR_EN);
        end
        m0_req = 0;
        @(negedge clk);
        want_d = ERR_EN ? 32'h0 : 32'hBAD0_BAD0;
        checks++;
        if (m0_ack !== 1'b1 || err !== ERR_EN || m0_rdata !== want_d) begin
            errors++;
            $display("FAIL err_done got ack%b err%b d=%h want ack1 err%b d=%h", m0_ack, err, m0_rdata, ERR_EN, want_d);
        end
        // misaligned RAM address
        m0_req = 1; m0_we = 0; m0_addr = 32'h2;
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got err%b want 0", err);
        end
        @(negedge clk);
        m0_req = 0;
        @(negedge clk);
        want_d = ERR_EN ? 32'h0 : 32'h64;
        checks++;
        if (m0_ack !== 1'b1 || err !== ERR_EN || m0_rdata !== want_d) begin
            errors++;
            $display("FAIL err_misalign got ack%b err%b d=%h want ack1 err%b d=%h", m0_ack, err, m0_rdata, ERR_EN, want_d);
        end
        @(negedge clk);
    endtask

    // ---------------- randomized two-master traffic ----------------
    task automatic drive_master(input int m, input int n);
        txn_t t;
        logic got;
        int   gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                if (m == 0) m0_req = 0; else m1_req = 0;
                repeat (gap) @(negedge clk);
            end
            if ($urandom_range(0, 9) < 8) t.addr = 32'(16 + $urandom_range(0, 15)) * 4;
            else                          t.addr = 32'h4000_0000 + 32'($urandom_range(0, 2)) * 4;
            t.we    = 1'($urandom_range(0, 1));
            t.wdata = $urandom;
            if (m == 0) q0.push_back(t); else q1.push_back(t);
            set_m(m, 1'b1, t);
            got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                got = (m == 0) ? m0_ack : m1_ack;
            end
            if (!got) begin
                errors++;
                $display("FAIL rnd_ack_timeout master %0d txn %0d", m, i);
            end
        end
        if (m == 0) m0_req = 0; else m1_req = 0;
    endtask

    task automatic monitor_random(input int total);
        int          acked;
        logic        x_seen;
        logic [31:0] x_addr, x_wdata, exp_d, got_d;
        logic        x_we;
        int          who;
        txn_t        t;
        acked = 0;
        x_seen = 0;
        x_addr = 0; x_wdata = 0; x_we = 0;
        for (int c = 0; c < 4000 && acked < total; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                who = m1_ack ? 1 : 0;
                checks++;
                if ((m0_ack && m1_ack) || !x_seen || (who == 0 ? q0.size() : q1.size()) == 0) begin
                    errors++;
                    $display("FAIL rnd_ack_protocol acks=%b xfer_seen=%b q0=%0d q1=%0d",
                             {m0_ack, m1_ack}, x_seen, q0.size(), q1.size());
                end else begin
                    t = (who == 0) ? q0.pop_front() : q1.pop_front();
                    checks++;
                    if (x_addr !== t.addr || x_we !== t.we || (t.we && x_wdata !== t.wdata) || err !== 1'b0) begin
                        errors++;
                        $display("FAIL rnd_xfer m%0d got a=%h we=%b d=%h err%b want a=%h we=%b d=%h err0",
                                 who, x_addr, x_we, x_wdata, err, t.addr, t.we, t.wdata);
                    end
                    if (t.we) begin
                        ref_mem[t.addr] = t.wdata;
                    end else begin
                        exp_d = ref_read(t.addr);
                        got_d = (who == 0) ? m0_rdata : m1_rdata;
                        checks++;
                        if (got_d !== exp_d) begin
                            errors++;
                            $display("FAIL rnd_rdata m%0d a=%h got %h want %h", who, t.addr, got_d, exp_d);
                        end
                    end
                end
                acked++;
                x_seen = 0;
            end
            if (mem_read || mem_write) begin
                x_seen = 1;
                x_addr = mem_addr; x_wdata = mem_wdata; x_we = mem_write;
            end
        end
        checks++;
        if (acked != total) begin
            errors++;
            $display("FAIL rnd_total got %0d acks want %0d", acked, total);
        end
    endtask

    task automatic test_random();
        q0.delete();
        q1.delete();
        ref_mem.delete();
        fork
            drive_master(0, 40);
            drive_master(1, 40);
            monitor_random(80);
        join
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL rnd_leftover got q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mmio_write_read();
        test_tie();
        test_alternate();
        test_hold_m1();
        test_reset_mid_xfer();
        test_err();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter for the shared data-memory/MMIO port: RAM, timer registers TH/TL/TCON and the digit register.
- Master 0 is the pipeline MEM stage; master 1 is the boot/debug loader.
- Each transaction uses a request/acknowledge handshake, round-robin arbitration and a three-state sequencer that drives the memory's single address/data/read/write port.

Parameters:
- ADDR_W, 32, address width of masters and memory port
- DATA_W, 32, data width of masters and memory port

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 transaction request, held until m0_ack
- m0_we  in  1  master 0: 1=write, 0=read
- m0_addr  in  ADDR_W  master 0 byte address
- m0_wdata  in  DATA_W  master 0 write data
- m0_rdata  out  DATA_W  master 0 read data, valid while m0_ack=1
- m0_ack  out  1  master 0 one-cycle completion pulse
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  same widths/meaning for master 1
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_rdata  in  DATA_W  combinational memory read data
- err  out  1  access fault flag (optional feature only; tied 0 otherwise)

Behaviour:
- FSM states: IDLE, XFER, DONE. Reset state is IDLE.
- Reset values: owner=0, last=1, all acks 0, mem_read/mem_write 0, mem_addr/mem_wdata 0, m*_rdata 0, err 0.
- IDLE: at a clock edge with any req high, register the winner into owner, latch that master's addr/wdata/we, then go to XFER. With no req, stay in IDLE.
- Arbitration: if only one master requests, it wins. If both request, the master != last wins, so master 0 wins the first tie after reset. last is updated to the winner on each grant.
- XFER (exactly one cycle):
  - mem_addr/mem_wdata come from the latched values.
  - mem_write = latched we; mem_read = !latched we. The memory commits a write at the XFER->DONE edge.
  - At that same edge, mem_rdata is registered into the owner's m*_rdata (read only; a write leaves rdata unchanged). The owner's ack is set. Next state is DONE.
- DONE (one cycle):
  - Owner's ack=1; mem_read/mem_write=0.
  - The acked master must drop req or present a new request; its req is ignored this cycle.
  - If the non-owner's req is high at the DONE edge, grant it directly (DONE->XFER). Otherwise go to IDLE.
- Latency: req seen at edge k gives XFER in cycle k..k+1 and ack high in cycle k+1..k+2. A single master gets back-to-back throughput of 1 transaction per 3 cycles; alternating masters get 1 per 2 cycles.
- Master inputs may change after the grant edge without affecting the transaction in flight.
- Only the owner's ack ever asserts; m0_ack and m1_ack are never high together.
- Reset during XFER: state returns to IDLE asynchronously, mem_write drops immediately, no ack is issued, and the transaction is discarded.

Optional Feature:
- Macro DMEM_ARB_ERR_EN.
- When defined, the latched address is decoded at grant. Legal addresses are 0x00000000-0x000007FF and exactly 0x40000000, 0x40000004, 0x40000008, 0x40000010; the address must also be word-aligned (addr[1:0]=0).
- An illegal address still passes through XFER with mem_read=mem_write=0. In DONE, ack is asserted, rdata=0 and err=1 for that single cycle.
- When not defined, no decode is done, every access is forwarded, and err is constant 0.

Test Plan:
- m0 write 0x40000010 data 0x0000000F: mem_write=1 for one cycle with mem_addr=0x40000010, m0_ack one cycle later; a following m0 read of 0x40000010 returns 0x0000000F in m0_rdata during its ack.
- m0_req and m1_req both raised at the same edge after reset (reads of 0x0 and 0x4): m0 is served first (rdata 0x64), then m1 via DONE->XFER (rdata 0xA). The acks are 2 cycles apart and never overlap.
- Both masters hold req continuously for 6 transactions: grants alternate 0,1,0,1,0,1.
- m1 holds req while m0 issues a single read: m1 is granted only after the m0 transaction; m0_addr changed during XFER does not alter mem_addr.
- Reset asserted mid-XFER of an m1 write to RAM word 5: mem_write falls immediately, no m1_ack, FSM in IDLE, and word 5 keeps its reset value 12.
- With DMEM_ARB_ERR_EN, an m0 read of 0x40000020 gives mem_read=0, m0_ack=1, err=1, m0_rdata=0. Without the macro, mem_read=1 and err=0.
